// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 mux channel: arbitrates four request
// lines, drives the mux select and bounds each grant to MAX_HOLD cycles.
module mux4_rr_scheduler #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] win;
  logic       release_now;

  // First set request bit found scanning upward from p, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win         = rr_pick(req, ptr_q);
  assign release_now = !req[sel_q] || (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          cnt_d   = 4'd0;
          ptr_d   = win + 2'd1;
          state_d = ST_GRANT;
        end
      end
      default: begin
        if (!release_now) begin
          cnt_d = cnt_q + 4'd1;
        end else if (|req) begin
          // Back-to-back handoff; ptr already points past the current owner.
          gnt_d = 4'b0001 << win;
          sel_d = win;
          cnt_d = 4'd0;
          ptr_d = win + 2'd1;
        end else begin
          gnt_d   = 4'b0000;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = (state_q == ST_GRANT);
  assign busy  = (state_q == ST_GRANT);

endmodule
